// File: rtl/delay_sideband_pipe.sv
// Enable-gated sideband flag delay line with hold, synchronous flush and an early-enable tap.
// Optional occupancy counter output occ_o is compiled in when DELAY_SB_OCC_EN is defined.
module delay_sideband_pipe #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned EN_TAP = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             hold_i,
  input  logic             clr_i,
`ifdef DELAY_SB_OCC_EN
  output logic [$clog2(DEPTH+1)-1:0] occ_o,
`endif
  output logic             en_o,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  generate
    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
      $error("delay_sideband_pipe: DEPTH must be in 1..16");
    end
    if (EN_TAP < 1 || EN_TAP > DEPTH) begin : g_bad_tap
      $error("delay_sideband_pipe: EN_TAP must be in 1..DEPTH");
    end
  endgenerate

  // Index 0 is stage 1, index DEPTH-1 is the final stage.
  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  always_comb begin
    v_d = v_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (clr_i) begin
      v_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_d[i] = '0;
      end
    end else if (!hold_i) begin
      v_d[0] = en_i;
      if (en_i) begin
        d_d[0] = data_i;
      end
      for (int unsigned i = 1; i < DEPTH; i++) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign en_o   = v_q[EN_TAP-1];
  assign vld_o  = v_q[DEPTH-1];
  assign data_o = d_q[DEPTH-1];

`ifdef DELAY_SB_OCC_EN
  localparam int unsigned OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occ_q, occ_d;

  // Tracks popcount of the valid chain without an adder tree.
  always_comb begin
    occ_d = occ_q;
    if (clr_i) begin
      occ_d = '0;
    end else if (!hold_i) begin
      if (en_i && !v_q[DEPTH-1]) begin
        occ_d = occ_q + OCC_W'(1);
      end else if (!en_i && v_q[DEPTH-1]) begin
        occ_d = occ_q - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o = occ_q;
`endif

endmodule

// File: tb/tb_delay_sideband_pipe.sv
// Self-checking bench for delay_sideband_pipe (WIDTH=3, DEPTH=4, EN_TAP=2) against a token-age model.
// Also checks occ_o when DELAY_SB_OCC_EN is defined.
module tb_delay_sideband_pipe;

  localparam int W   = 3;
  localparam int D   = 4;
  localparam int TAP = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         hold_i = 1'b0;
  logic         clr_i = 1'b0;
  logic         en_o, vld_o;
  logic [W-1:0] data_o;
`ifdef DELAY_SB_OCC_EN
  logic [$clog2(D+1)-1:0] occ_o;
`endif

  delay_sideband_pipe #(.WIDTH(W), .DEPTH(D), .EN_TAP(TAP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .data_i (data_i),
    .hold_i (hold_i),
    .clr_i  (clr_i),
`ifdef DELAY_SB_OCC_EN
    .occ_o  (occ_o),
`endif
    .en_o   (en_o),
    .vld_o  (vld_o),
    .data_o (data_o)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference: list of in-flight tokens, each with its age in advancing edges.
  typedef struct {
    int           age;
    logic [W-1:0] data;
  } tok_t;
  tok_t         toks[$];
  logic [W-1:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic any_age(input int a);
    foreach (toks[i]) if (toks[i].age == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    toks.delete();
    m_data = '0;
  endtask

  task automatic model_edge(input logic e, input logic [W-1:0] dat, input logic h, input logic c);
    tok_t t;
    if (c) begin
      model_reset();
    end else if (!h) begin
      foreach (toks[i]) toks[i].age++;
      if (e) begin
        t.age  = 1;
        t.data = dat;
        toks.push_back(t);
      end
      foreach (toks[i]) if (toks[i].age == D) m_data = toks[i].data;
      for (int i = toks.size() - 1; i >= 0; i--) begin
        if (toks[i].age > D) toks.delete(i);
      end
    end
  endtask

  task automatic compare_all();
    check("en_o", {31'd0, en_o}, {31'd0, any_age(TAP)});
    check("vld_o", {31'd0, vld_o}, {31'd0, any_age(D)});
    check("data_o", {29'd0, data_o}, {29'd0, m_data});
`ifdef DELAY_SB_OCC_EN
    check("occ_o", {29'd0, occ_o}, toks.size());
`endif
  endtask

  task automatic step(input logic e, input logic [W-1:0] dat, input logic h, input logic c);
    en_i   = e;
    data_i = dat;
    hold_i = h;
    clr_i  = c;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(e, dat, h, c);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("reset_vld", {31'd0, vld_o}, 32'd0);
    check("reset_data", {29'd0, data_o}, 32'd0);
    rst_n = 1'b1;

    // Single pulse
    step(1'b1, 3'b101, 1'b0, 1'b0);
    idle(1);
    check("t1_en_c2", {31'd0, en_o}, 32'd1);
    idle(2);
    check("t1_vld_c4", {31'd0, vld_o}, 32'd1);
    check("t1_data_c4", {29'd0, data_o}, 32'd5);
    idle(6);
    check("t1_data_c10", {29'd0, data_o}, 32'd5);
    check("t1_vld_c10", {31'd0, vld_o}, 32'd0);

    // Back-to-back tokens
    step(1'b1, 3'b001, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b100, 1'b0, 1'b0);
    idle(1);
    check("t2_data_c4", {29'd0, data_o}, 32'd1);
    idle(1);
    check("t2_data_c5", {29'd0, data_o}, 32'd2);
    idle(1);
    check("t2_data_c6", {29'd0, data_o}, 32'd4);
    idle(4);

    // Hold stretches latency
    step(1'b1, 3'b110, 1'b0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("t3_en_c4", {31'd0, en_o}, 32'd1);
    idle(2);
    check("t3_vld_c6", {31'd0, vld_o}, 32'd1);
    check("t3_data_c6", {29'd0, data_o}, 32'd6);
    idle(3);

    // Flush with a same-cycle token
    step(1'b1, 3'b011, 1'b0, 1'b0);
    step(1'b1, 3'b111, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b1);
    check("t4_data_c3", {29'd0, data_o}, 32'd0);
    check("t4_en_c3", {31'd0, en_o}, 32'd0);
    idle(5);
    check("t4_vld_late", {31'd0, vld_o}, 32'd0);

    // Asynchronous reset mid-flight
    step(1'b1, 3'b101, 1'b0, 1'b0);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("t5_en_async", {31'd0, en_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    check("t5_no_vld", {31'd0, vld_o}, 32'd0);
    step(1'b1, 3'b011, 1'b0, 1'b0);
    idle(3);
    check("t5_new_vld", {31'd0, vld_o}, 32'd1);
    check("t5_new_data", {29'd0, data_o}, 32'd3);

    // Continuous stream (occupancy saturates at DEPTH)
    for (int i = 0; i < 6; i++) step(1'b1, 3'($urandom), 1'b0, 1'b0);
    idle(5);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
